// File: rtl/dff_share_arb.sv
// Round-robin arbiter that shares one registered WIDTH-bit sample point among NREQ requesters.
// Optional feature macro: DFF_ARB_PRIO_EN (requester 0 always wins when it requests).
module dff_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2,
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic                  c,
  input  logic                  r,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] d,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  q_vld,
  output logic [OW-1:0]         q_owner,
  output logic                  busy
);

  // Handshake: a requester holds req and d until it sees its 1-cycle ack; any req
  // still high at an arbitration edge (IDLE edge or terminal HOLD edge) is a new request.
  typedef enum logic {IDLE = 1'b0, HOLD_S = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [OW-1:0]   ptr;
  logic [OW-1:0]   win;
  logic            found;
  logic            prio_hit;
  logic            grant;
  logic            terminal;
  int              idx;

  assign terminal = (cnt == CW'(HOLD - 1));
  assign busy     = (state == HOLD_S);

  // Winner search starts just past the last winner so it has lowest priority.
  always_comb begin
    win      = '0;
    found    = 1'b0;
    prio_hit = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        win   = OW'(idx);
        found = 1'b1;
      end
    end
`ifdef DFF_ARB_PRIO_EN
    if (req[0]) begin
      win      = '0;
      prio_hit = 1'b1;
    end
`else
    prio_hit = 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) grant = 1'b1;
      end
      HOLD_S: begin
        if (terminal) begin
          if (|req) grant = 1'b1;
          else      state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant) state_nxt = HOLD_S;
  end

  always_ff @(posedge c) begin
    if (r) begin
      state   <= IDLE;
      q       <= '0;
      q_vld   <= 1'b0;
      q_owner <= '0;
      ack     <= '0;
      cnt     <= '0;
      ptr     <= OW'(NREQ - 1);
    end else begin
      state <= state_nxt;
      ack   <= '0;
      if (grant) begin
        q       <= d[int'(win)*WIDTH +: WIDTH];
        q_owner <= win;
        ack     <= NREQ'(1) << win;
        q_vld   <= 1'b1;
        cnt     <= '0;
        // A priority grant to requester 0 leaves the rotation among the others intact.
        if (!prio_hit) ptr <= win;
      end else if (state == HOLD_S) begin
        if (terminal) begin
          q_vld <= 1'b0;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dff_share_arb.sv
// Directed bench for dff_share_arb: a vector table for single-cycle behaviour plus
// hand-written sequences for round-robin rotation, priority mode and HOLD=1 streaming.
module tb_dff_share_arb;

  logic        c;
  logic        r, r1;
  logic [3:0]  req, req1;
  logic [31:0] d, d1;
  logic [3:0]  ack, ack1;
  logic [7:0]  q, q1;
  logic        q_vld, q_vld1;
  logic [1:0]  q_owner, q_owner1;
  logic        busy, busy1;

  int total = 0;
  int bad   = 0;

  dff_share_arb #(.NREQ(4), .WIDTH(8), .HOLD(2)) dut (
    .c(c), .r(r), .req(req), .d(d), .ack(ack), .q(q),
    .q_vld(q_vld), .q_owner(q_owner), .busy(busy)
  );

  dff_share_arb #(.NREQ(4), .WIDTH(8), .HOLD(1)) dut1 (
    .c(c), .r(r1), .req(req1), .d(d1), .ack(ack1), .q(q1),
    .q_vld(q_vld1), .q_owner(q_owner1), .busy(busy1)
  );

  // clock / reset
  initial c = 1'b0;
  always #5 c = ~c;

  typedef struct {
    logic        r;
    logic [3:0]  req;
    logic [31:0] d;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        vld;
    logic [1:0]  own;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rr, input logic [3:0] rq, input logic [31:0] dd,
                     input logic [3:0] ea, input logic [7:0] eq, input logic ev,
                     input logic [1:0] eo, input logic eb);
    vec_t v;
    v.r = rr; v.req = rq; v.d = dd; v.ack = ea; v.q = eq;
    v.vld = ev; v.own = eo; v.busy = eb;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: apply inputs, clock one edge, sample 1 time unit later
  task automatic step(input logic rr, input logic [3:0] rq, input logic [31:0] dd);
    r = rr; req = rq; d = dd;
    @(posedge c);
    #1;
  endtask

  logic [1:0] exp_owner_q[$];

  initial begin
    r = 1'b1; req = '0; d = '0;
    r1 = 1'b1; req1 = '0; d1 = '0;
    #2;

    // single grant, idle return
    add(1, 4'b0000, 32'h0,        4'b0000, 8'h00, 0, 0, 0);
    add(0, 4'b0001, 32'h000000A5, 4'b0001, 8'hA5, 1, 0, 1);
    add(0, 4'b0000, 32'h0,        4'b0000, 8'hA5, 1, 0, 1);
    add(0, 4'b0000, 32'h0,        4'b0000, 8'hA5, 0, 0, 0);
    // wrap-around ordering after winner 3
    add(0, 4'b1000, 32'h44332211, 4'b1000, 8'h44, 1, 3, 1);
    add(0, 4'b1010, 32'h44332211, 4'b0000, 8'h44, 1, 3, 1);
    add(0, 4'b1010, 32'h44332211, 4'b0010, 8'h22, 1, 1, 1);
    add(0, 4'b1000, 32'h44332211, 4'b0000, 8'h22, 1, 1, 1);
    add(0, 4'b1000, 32'h44332211, 4'b1000, 8'h44, 1, 3, 1);
    add(0, 4'b0001, 32'h44332211, 4'b0000, 8'h44, 1, 3, 1);
    add(0, 4'b0001, 32'h44332211, 4'b0001, 8'h11, 1, 0, 1);
    // reset mid-HOLD discards the sample, then requester 0 wins first
    add(1, 4'b0000, 32'h0,        4'b0000, 8'h00, 0, 0, 0);
    add(0, 4'b0001, 32'h0000005A, 4'b0001, 8'h5A, 1, 0, 1);
    add(1, 4'b0000, 32'h0,        4'b0000, 8'h00, 0, 0, 0);
    add(0, 4'b1111, 32'h13121110, 4'b0001, 8'h10, 1, 0, 1);
    add(0, 4'b0000, 32'h0,        4'b0000, 8'h10, 1, 0, 1);
    add(0, 4'b0000, 32'h0,        4'b0000, 8'h10, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].req, tbl[i].d);
      chk($sformatf("v%0d_ack", i),   32'(ack),     32'(tbl[i].ack));
      chk($sformatf("v%0d_q", i),     32'(q),       32'(tbl[i].q));
      chk($sformatf("v%0d_vld", i),   32'(q_vld),   32'(tbl[i].vld));
      chk($sformatf("v%0d_owner", i), 32'(q_owner), 32'(tbl[i].own));
      chk($sformatf("v%0d_busy", i),  32'(busy),    32'(tbl[i].busy));
    end

    // all four requesting, back-to-back grants, then requester 0 drops out
`ifdef DFF_ARB_PRIO_EN
    exp_owner_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
`else
    exp_owner_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
`endif
    step(1, 4'b0000, 32'h0);
    for (int g = 0; g < 7; g++) begin
      logic [3:0] rq;
      logic [1:0] eo;
      logic [7:0] eq;
      rq = (g < 4) ? 4'b1111 : 4'b1110;
      eo = exp_owner_q[g];
      eq = 8'h10 + 8'(eo);
      step(0, rq, 32'h13121110);
      chk($sformatf("rr%0d_ack", g),   32'(ack),     32'(4'b0001 << eo));
      chk($sformatf("rr%0d_owner", g), 32'(q_owner), 32'(eo));
      chk($sformatf("rr%0d_q", g),     32'(q),       32'(eq));
      chk($sformatf("rr%0d_vld", g),   32'(q_vld),   32'(1));
      step(0, rq, 32'h13121110);
      chk($sformatf("rr%0d_hold_ack", g), 32'(ack),   32'(0));
      chk($sformatf("rr%0d_hold_vld", g), 32'(q_vld), 32'(1));
      chk($sformatf("rr%0d_hold_own", g), 32'(q_owner), 32'(eo));
    end

    // HOLD=1: a lone continuous requester is granted every cycle
    r1 = 1'b1;
    @(posedge c); #1;
    chk("h1_reset_vld", 32'(q_vld1), 32'(0));
    chk("h1_reset_busy", 32'(busy1), 32'(0));
    r1 = 1'b0; req1 = 4'b0100; d1 = 32'h00770000;
    for (int k = 0; k < 6; k++) begin
      @(posedge c); #1;
      chk($sformatf("h1_%0d_ack", k),   32'(ack1),     32'(4'b0100));
      chk($sformatf("h1_%0d_vld", k),   32'(q_vld1),   32'(1));
      chk($sformatf("h1_%0d_owner", k), 32'(q_owner1), 32'(2));
      chk($sformatf("h1_%0d_q", k),     32'(q1),       32'(8'h77));
    end
    req1 = 4'b0000;
    @(posedge c); #1;
    chk("h1_release_ack", 32'(ack1),  32'(0));
    chk("h1_release_vld", 32'(q_vld1), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
